seq_det_pattern_fsm: RTL
========================

// Module: seq_det_pattern_fsm
// PURPOSE
//  Parametrised Moore serial-pattern detector, successor to the fixed-pattern detectors.
//  Pattern, pattern length and overlap mode are runtime-programmable.
//  A valid qualifier gates the input stream, and a saturating counter tracks matches.
//  Sits on a 1-bit serial input stream; detector_out is a registered one-cycle match pulse.
// PARAMETERS
//  MAX_LEN     8          maximum pattern length in bits (2..32)
//  CNT_W       8          width of match_count
//  DEF_PATTERN 8'b1011    pattern loaded at reset (LSB-aligned, MAX_LEN bits)
//  DEF_LEN     4          pattern length loaded at reset
//  DEF_OVL     1          overlap mode at reset (1 = overlapping matches allowed)
// PORTS
//  clock          in   1            rising-edge clock
//  reset          in   1            asynchronous, active-low reset
//  cfg_we         in   1            load cfg_* into configuration registers this cycle
//  cfg_pattern    in   MAX_LEN      pattern; bit [len-1] is the first bit received
//  cfg_len        in   LW           pattern length, LW = $clog2(MAX_LEN+1)
//  cfg_overlap    in   1            1 = overlapping, 0 = non-overlapping detection
//  sequence_valid in   1            sequence_in is sampled only when high
//  sequence_in    in   1            serial data bit
//  count_clear    in   1            synchronous clear of match_count
//  detector_out   out  1            one-cycle match pulse (registered, Moore)
//  match_count    out  CNT_W        saturating number of matches
//  armed          out  1            high once fill >= len-1 (next valid bit can match)
// BEHAVIOUR
//  Reset (reset=0, async): pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVL, hist=0, fill=0.
//    Also during reset: detector_out=0, match_count=0, armed=0.
//  State: hist[MAX_LEN-1:0] is the shift history; fill (0..len) counts valid bits since the last flush.
//  Accept cycle = sequence_valid=1 and cfg_we=0.
//    hist <= {hist[MAX_LEN-2:0], sequence_in}.
//    fill <= min(fill+1, len).
//  Match condition (accept cycle): fill+1 >= len AND {hist[len-2:0],sequence_in} == pattern[len-1:0].
//    Only the low len bits are compared; upper pattern bits are ignored.
//  Output timing: detector_out=1 in the cycle after the match accept cycle, for exactly one cycle.
//    detector_out is 0 otherwise, and 0 when sequence_valid is low. Latency is 1 clock.
//  Overlap=1: hist and fill are kept after a match.
//    Example: 11 in 111 gives 2 matches.
//  Overlap=0: fill is set to 0 on a match, so the next match needs len fresh bits.
//    Example: 11 in 1111 gives 2 matches; in 111 it gives 1.
//  Non-accept cycles (sequence_valid=0): hist, fill and the FSM hold; no match is possible.
//  Config write (cfg_we=1):
//    - Registers are updated, hist=0 and fill=0.
//    - Any sequence_in that cycle is discarded; detector_out=0 the next cycle.
//    - match_count is NOT cleared.
//  cfg_len clamp: 0 or 1 loads as 1 (single-bit detector); values > MAX_LEN load as MAX_LEN.
//  match_count increments by 1 on each match and saturates at 2^CNT_W-1 (no wrap).
//  count_clear=1: match_count <= 0, or 1 if a match occurs in the same cycle.
//  armed = (fill >= len-1) as a registered/state-derived signal; it drops to 0 on a config write.
//  Reset mid-stream: all state returns to reset values immediately; any partial pattern is lost.
//  Internal control FSM: IDLE (fill=0) -> FILL (0<fill<len-1) -> ARMED (fill>=len-1).
//    ARMED -> IDLE on a non-overlap match or a config write; FILL -> IDLE on a config write.
// TESTING
//  1 After reset, defaults 1011 overlap, valid=1, stream 1,0,1,1,0,1,1:
//    detector_out pulses after bit 4 and bit 7; match_count=2.
//  2 Config pattern 2'b11, len 2, overlap=0, stream 1,1,1,1,1:
//    2 pulses (bits 2,4); repeat with overlap=1 -> 4 pulses.
//  3 Default 1011 with valid low between every bit:
//    match still found, pulse exactly 1 cycle after the 4th valid bit.
//  4 Send 1,0,1 then cfg_we (same pattern), then 1:
//    no pulse; needs a full fresh 1011.
//  5 CNT_W=4, 20 matches -> match_count=15.
//    count_clear together with a match -> 1.
//  6 Assert reset after 1,0,1; release, send 1:
//    no pulse; detector_out and match_count are 0 during reset.

Source files
------------

// File: rtl/seq_det_pattern_fsm_if.sv
// Bus bundle for the programmable serial pattern detector: configuration,
// qualified serial input, and match reporting.
interface seq_det_pattern_fsm_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic               cfg_overlap;
  logic               sequence_valid;
  logic               sequence_in;
  logic               count_clear;
  logic               detector_out;
  logic [CNT_W-1:0]   match_count;
  logic               armed;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap,
    output sequence_valid, sequence_in, count_clear,
    input  detector_out, match_count, armed
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap,
    input  sequence_valid, sequence_in, count_clear,
    output detector_out, match_count, armed
  );
endinterface

// File: rtl/seq_det_pattern_fsm.sv
// Moore serial-pattern detector with runtime pattern/length/overlap, a valid
// qualifier and a saturating match counter.
module seq_det_pattern_fsm #(
  parameter int unsigned           MAX_LEN     = 8,
  parameter int unsigned           CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]    DEF_PATTERN = MAX_LEN'('b1011),
  parameter int unsigned           DEF_LEN     = 4,
  parameter bit                    DEF_OVL     = 1'b1
) (
  input logic               clock,
  input logic               reset,
  seq_det_pattern_fsm_if.slave bus
);
  localparam int unsigned      LW      = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0]    DefLen  = LW'(DEF_LEN);
  localparam logic [LW-1:0]    MaxLenC = LW'(MAX_LEN);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  typedef enum logic [1:0] {StIdle, StFill, StArmed} state_e;

  logic [MAX_LEN-1:0] r_pattern, w_pattern_d;
  logic [LW-1:0]      r_len, w_len_d;
  logic               r_ovl, w_ovl_d;
  logic [MAX_LEN-1:0] r_hist, w_hist_d;
  logic [LW-1:0]      r_fill, w_fill_d;
  state_e             r_state, w_state_d;
  logic               r_det, w_det_d;
  logic [CNT_W-1:0]   r_count, w_count_d;

  logic [MAX_LEN-1:0] w_shift;
  logic [MAX_LEN-1:0] w_mask;
  logic [LW:0]        w_fill_inc;
  logic [LW-1:0]      w_len_clamp;
  logic               w_match;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pattern <= DEF_PATTERN;
      r_len     <= DefLen;
      r_ovl     <= DEF_OVL;
      r_hist    <= '0;
      r_fill    <= '0;
      r_state   <= StIdle;
      r_det     <= 1'b0;
      r_count   <= '0;
    end else begin
      r_pattern <= w_pattern_d;
      r_len     <= w_len_d;
      r_ovl     <= w_ovl_d;
      r_hist    <= w_hist_d;
      r_fill    <= w_fill_d;
      r_state   <= w_state_d;
      r_det     <= w_det_d;
      r_count   <= w_count_d;
    end
  end

  always_comb begin
    w_pattern_d = r_pattern;
    w_len_d     = r_len;
    w_ovl_d     = r_ovl;
    w_hist_d    = r_hist;
    w_fill_d    = r_fill;
    w_count_d   = r_count;
    w_match     = 1'b0;
    w_shift     = {r_hist[MAX_LEN-2:0], bus.sequence_in};
    w_fill_inc  = {1'b0, r_fill} + 1'b1;

    // Only the low len bits of the history take part in the comparison.
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < 32'(r_len));
    end

    if (bus.cfg_len == '0) begin
      w_len_clamp = LW'(1);
    end else if (bus.cfg_len > MaxLenC) begin
      w_len_clamp = MaxLenC;
    end else begin
      w_len_clamp = bus.cfg_len;
    end

    if (bus.cfg_we) begin
      w_pattern_d = bus.cfg_pattern;
      w_len_d     = w_len_clamp;
      w_ovl_d     = bus.cfg_overlap;
      w_hist_d    = '0;
      w_fill_d    = '0;
    end else if (bus.sequence_valid) begin
      w_hist_d = w_shift;
      w_match  = (w_fill_inc >= {1'b0, r_len}) && (((w_shift ^ r_pattern) & w_mask) == '0);
      if (w_match && !r_ovl) begin
        w_fill_d = '0;
      end else if (w_fill_inc > {1'b0, r_len}) begin
        w_fill_d = r_len;
      end else begin
        w_fill_d = w_fill_inc[LW-1:0];
      end
    end

    w_det_d = w_match;

    if (bus.count_clear) begin
      w_count_d = w_match ? CNT_W'(1) : '0;
    end else if (w_match && (r_count != CntMax)) begin
      w_count_d = r_count + 1'b1;
    end

    // Armed takes priority so a single-bit pattern is armed straight after a flush.
    if (({1'b0, w_fill_d} + 1'b1) >= {1'b0, w_len_d}) begin
      w_state_d = StArmed;
    end else if (w_fill_d == '0) begin
      w_state_d = StIdle;
    end else begin
      w_state_d = StFill;
    end
  end

  assign bus.detector_out = r_det;
  assign bus.match_count  = r_count;
  assign bus.armed        = (r_state == StArmed);

endmodule
